// File: rtl/j1_irq_ctrl.sv
// j1_irq_ctrl: interrupt controller sitting directly upstream of the j1 core.
// Latches NSRC request lines as pending, masks them, and issues a one-cycle
// "interrupt" pulse (the core then executes "call 3FFE").
// Optional feature macro: IRQ_SYNC_EN -- when defined, each irq_src bit goes
// through a 2-flop synchronizer before edge detection (2 extra cycles).
//
// IO strobe semantics: io_rd/io_wr are single-cycle strobes from the core with
// no back-pressure. A write takes effect at the clock edge that ends its
// io_wr cycle. A read returns data combinationally in the io_rd cycle and has
// no side effects. io_rdata is 0 whenever io_rd is low or the address is not
// in this block's 8-byte window.
module j1_irq_ctrl #(
    parameter int              NSRC      = 8,
    parameter logic [15:0]     BASE      = 16'h0100,
    parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     io_addr,
    input  logic [15:0]     io_wdata,
    output logic [15:0]     io_rdata,
    input  logic [NSRC-1:0] irq_src,
    input  logic            hold,
    output logic            interrupt
);

    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_MASK  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_prev;
    logic            r_gie;
    logic            r_int;

    logic            w_sel;
    logic [1:0]      w_idx;
    logic            w_wr_pend;
    logic            w_wr_mask;
    logic            w_wr_ctrl;
    logic [NSRC-1:0] w_src;
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_hit;
    logic            w_req;
    logic [3:0]      w_cause_idx;
    logic            w_cause_valid;
    logic            w_unused;

    // Address decode: 8-byte window, word index in [2:1], byte bit ignored.
    assign w_sel     = (io_addr[15:3] == BASE[15:3]);
    assign w_idx     = io_addr[2:1];
    assign w_wr_pend = io_wr & w_sel & (w_idx == REG_PEND);
    assign w_wr_mask = io_wr & w_sel & (w_idx == REG_MASK);
    assign w_wr_ctrl = io_wr & w_sel & (w_idx == REG_CTRL);
    assign w_unused  = &{1'b0, io_addr[0], io_wdata};

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    // Two-flop synchronizer so asynchronous sources can be connected.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end
    assign w_src = r_sync2;
`else
    assign w_src = irq_src;
`endif

    // Edge sources: a rising edge sets, W1C clears, and a set beats a clear.
    // Level sources simply follow the (possibly synchronized) input.
    assign w_edge     = w_src & ~r_prev;
    assign w_clr      = w_wr_pend ? io_wdata[NSRC-1:0] : '0;
    assign w_pend_nxt = (EDGE_MASK & ((r_pend & ~w_clr) | w_edge))
                      | (~EDGE_MASK & w_src);

    // Request uses registered state only, never same-cycle write data.
    assign w_hit = r_pend & r_mask;
    assign w_req = r_gie & (|w_hit) & ~hold;

    // Lowest-numbered enabled pending source wins the CAUSE report.
    always_comb begin
        w_cause_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_cause_idx = 4'(i);
            end
        end
    end
    assign w_cause_valid = |w_hit;

    // Combinational read mux; zero outside a selected read.
    always_comb begin
        io_rdata = '0;
        if (io_rd && w_sel) begin
            case (w_idx)
                REG_PEND: io_rdata[NSRC-1:0] = r_pend;
                REG_MASK: io_rdata[NSRC-1:0] = r_mask;
                REG_CTRL: io_rdata[0]        = r_gie;
                default:  io_rdata = {w_cause_valid, 11'd0, w_cause_idx};
            endcase
        end
    end

    // Register state; issuing clears GIE and overrides a same-edge GIE write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_mask <= '0;
            r_prev <= '0;
            r_gie  <= 1'b0;
            r_int  <= 1'b0;
        end else begin
            r_prev <= w_src;
            r_pend <= w_pend_nxt;
            r_int  <= w_req;
            if (w_wr_mask) begin
                r_mask <= io_wdata[NSRC-1:0];
            end
            if (w_req) begin
                r_gie <= 1'b0;
            end else if (w_wr_ctrl) begin
                r_gie <= io_wdata[0];
            end
        end
    end

    assign interrupt = r_int;

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// tb_j1_irq_ctrl: directed vector table for the documented scenarios, then
// randomized traffic checked against a rule-level reference model.
// The directed table assumes the default build (IRQ_SYNC_EN undefined).
module tb_j1_irq_ctrl;

  localparam int          NSRC      = 8;
  localparam logic [15:0] BASE      = 16'h0100;
  localparam logic [7:0]  EDGE_MASK = 8'hF7;   // source 3 is level
  localparam logic [15:0] A_PEND    = 16'h0100;
  localparam logic [15:0] A_MASK    = 16'h0102;
  localparam logic [15:0] A_CTRL    = 16'h0104;
  localparam logic [15:0] A_CAUSE   = 16'h0106;

  // ---------------- clock / reset / drive ----------------
  logic        clk = 1'b0;
  logic        d_rst = 1'b1;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [7:0]  d_src = '0;
  logic        d_hold = 1'b0;
  logic [15:0] io_rdata;
  logic        interrupt;

  always #5 clk = ~clk;

  j1_irq_ctrl #(.NSRC(NSRC), .BASE(BASE), .EDGE_MASK(EDGE_MASK)) dut (
    .clk(clk), .reset(d_rst), .io_rd(d_rd), .io_wr(d_wr),
    .io_addr(d_addr), .io_wdata(d_wdata), .io_rdata(io_rdata),
    .irq_src(d_src), .hold(d_hold), .interrupt(interrupt)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the register file as the rules describe it: what each source
  // contributes to pending, what software writes do, and when a request fires.
  logic [7:0] m_pend, m_mask, m_prev, m_d1, m_d2;
  logic       m_gie, m_int;

  function automatic logic m_sel(input logic [15:0] a);
    return (a >> 3) == (BASE >> 3);
  endfunction

  function automatic logic [15:0] m_read(input logic rd, input logic [15:0] a);
    int idx;
    if (!rd || !m_sel(a)) return 16'h0000;
    idx = (a >> 1) & 3;
    if (idx == 0) return {8'h00, m_pend};
    if (idx == 1) return {8'h00, m_mask};
    if (idx == 2) return {15'd0, m_gie};
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_mask[i]) return 16'h8000 + 16'(i);
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    logic [7:0] s;
    logic       fire;
    int         widx;
    if (d_rst) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_d1 = '0; m_d2 = '0;
      m_gie = 1'b0; m_int = 1'b0;
    end else begin
`ifdef IRQ_SYNC_EN
      s = m_d2; m_d2 = m_d1; m_d1 = d_src;
`else
      s = d_src;
`endif
      fire = m_gie && ((m_pend & m_mask) != 0) && !d_hold;
      widx = (d_wr && m_sel(d_addr)) ? ((d_addr >> 1) & 3) : -1;
      for (int i = 0; i < NSRC; i++) begin
        if (EDGE_MASK[i]) begin
          if (s[i] && !m_prev[i]) m_pend[i] = 1'b1;
          else if (widx == 0 && d_wdata[i]) m_pend[i] = 1'b0;
        end else begin
          m_pend[i] = s[i];
        end
      end
      if (widx == 1) m_mask = d_wdata[7:0];
      if (fire) m_gie = 1'b0;
      else if (widx == 2) m_gie = d_wdata[0];
      m_int = fire;
      m_prev = s;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] addr, wdata;
    logic [7:0]  src;
    logic        hold;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        chk_int;
    logic        exp_int;
  } row_t;

  row_t rows[$];

  task automatic add_row(input logic rst, rd, wr, input logic [15:0] a, d,
                         input logic [7:0] src, input logic hold, chk_rd,
                         input logic [15:0] exp_rd, input logic chk_int, exp_int);
    row_t r;
    r = '{rst, rd, wr, a, d, src, hold, chk_rd, exp_rd, chk_int, exp_int};
    rows.push_back(r);
  endtask

  task automatic t_rst(input logic c);
    add_row(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 8'hFF, 1'b0, 1'b0, 16'h0, c, 1'b0);
  endtask
  task automatic t_idle(input logic [7:0] src, input logic hold, input logic ei);
    add_row(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, src, hold, 1'b0, 16'h0, 1'b1, ei);
  endtask
  task automatic t_wr(input logic [15:0] a, d, input logic [7:0] src, input logic ei);
    add_row(1'b0, 1'b0, 1'b1, a, d, src, 1'b0, 1'b0, 16'h0, 1'b1, ei);
  endtask
  task automatic t_rd(input logic [15:0] a, e, input logic [7:0] src, input logic ei);
    add_row(1'b0, 1'b1, 1'b0, a, 16'h0, src, 1'b0, 1'b1, e, 1'b1, ei);
  endtask

  task automatic build_table();
    // reset with all sources high, then everything reads zero
    t_rst(1'b0); t_rst(1'b1); t_rst(1'b1);
    t_rd(A_PEND, 16'h0000, 8'h00, 1'b0);
    t_rd(A_MASK, 16'h0000, 8'h00, 1'b0);
    t_rd(A_CTRL, 16'h0000, 8'h00, 1'b0);
    t_rd(A_CAUSE, 16'h0000, 8'h00, 1'b0);
    // edge IRQ on source 2
    t_wr(A_MASK, 16'h0004, 8'h00, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h00, 1'b0);
    t_idle(8'h04, 1'b0, 1'b0);
    t_rd(A_PEND, 16'h0004, 8'h00, 1'b0);
    t_rd(A_CTRL, 16'h0000, 8'h00, 1'b1);
    t_rd(A_CAUSE, 16'h8002, 8'h00, 1'b0);
    t_rd(A_PEND, 16'h0004, 8'h00, 1'b0);
    // priority and W1C
    t_wr(A_PEND, 16'h0004, 8'h00, 1'b0);
    t_wr(A_MASK, 16'h0022, 8'h00, 1'b0);
    t_idle(8'h22, 1'b0, 1'b0);
    t_rd(A_CAUSE, 16'h8001, 8'h00, 1'b0);
    t_wr(A_PEND, 16'h0002, 8'h00, 1'b0);
    t_rd(A_CAUSE, 16'h8005, 8'h00, 1'b0);
    t_wr(A_PEND, 16'h0020, 8'h00, 1'b0);
    t_rd(A_CAUSE, 16'h0000, 8'h00, 1'b0);
    // hold deferral
    t_wr(A_MASK, 16'h0001, 8'h01, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) t_idle(8'h00, 1'b1, 1'b0);
    t_idle(8'h00, 1'b0, 1'b0);
    t_rd(A_CTRL, 16'h0000, 8'h00, 1'b1);
    t_idle(8'h00, 1'b0, 1'b0);
    t_wr(A_PEND, 16'h0001, 8'h00, 1'b0);
    // level source 3
    t_wr(A_MASK, 16'h0008, 8'h08, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h08, 1'b0);
    t_idle(8'h08, 1'b0, 1'b0);
    t_wr(A_PEND, 16'h0008, 8'h08, 1'b1);
    t_rd(A_PEND, 16'h0008, 8'h08, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h08, 1'b0);
    t_idle(8'h08, 1'b0, 1'b0);
    t_rd(A_CTRL, 16'h0000, 8'h08, 1'b1);
    t_idle(8'h00, 1'b0, 1'b0);
    t_rd(A_PEND, 16'h0000, 8'h00, 1'b0);
    // edge set colliding with W1C of the same bit
    t_wr(A_MASK, 16'h0000, 8'h00, 1'b0);
    t_wr(A_PEND, 16'h0001, 8'h01, 1'b0);
    t_rd(A_PEND, 16'h0001, 8'h00, 1'b0);
    // GIE write colliding with issue
    t_wr(A_MASK, 16'h0001, 8'h00, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h00, 1'b0);
    t_wr(A_CTRL, 16'h0001, 8'h00, 1'b0);
    t_rd(A_CTRL, 16'h0000, 8'h00, 1'b1);
    t_rd(A_CTRL, 16'h0000, 8'h00, 1'b0);
    // decode corners
    t_wr(A_PEND, 16'h0001, 8'h00, 1'b0);
    t_wr(A_MASK, 16'hFFFF, 8'h00, 1'b0);
    t_rd(16'h0103, 16'h00FF, 8'h00, 1'b0);
    add_row(1'b0, 1'b0, 1'b0, A_MASK, 16'h0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    t_rd(16'h0108, 16'h0000, 8'h00, 1'b0);
    t_rd(16'h0200, 16'h0000, 8'h00, 1'b0);
    t_rd(A_CAUSE, 16'h0000, 8'h00, 1'b0);
    t_wr(A_MASK, 16'h0000, 8'h00, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic prev_int;
    build_table();

`ifndef IRQ_SYNC_EN
    foreach (rows[i]) begin
      @(negedge clk);
      d_rst = rows[i].rst; d_rd = rows[i].rd; d_wr = rows[i].wr;
      d_addr = rows[i].addr; d_wdata = rows[i].wdata;
      d_src = rows[i].src; d_hold = rows[i].hold;
      #1;
      if (rows[i].chk_rd)
        check($sformatf("row%0d io_rdata", i), io_rdata, rows[i].exp_rd);
      if (rows[i].chk_int)
        check($sformatf("row%0d interrupt", i), {15'd0, interrupt}, {15'd0, rows[i].exp_int});
    end
`endif

    // randomized traffic against the reference model
    @(negedge clk);
    d_rst = 1'b1; d_rd = 1'b0; d_wr = 1'b0; d_src = '0; d_hold = 1'b0;
    @(negedge clk);
    prev_int = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      d_rst = ($urandom_range(0, 199) == 0);
      d_rd  = $urandom_range(0, 1);
      d_wr  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8)
        d_addr = BASE + 16'(2 * $urandom_range(0, 3)) + 16'($urandom_range(0, 1));
      else
        d_addr = 16'($urandom_range(0, 65535));
      d_wdata = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) d_wdata[0] = 1'b1;
      d_src  = d_src ^ (8'($urandom) & 8'($urandom));
      d_hold = ($urandom_range(0, 3) == 0);
      #1;
      check($sformatf("rand%0d io_rdata", n), io_rdata, m_read(d_rd, d_addr));
      check($sformatf("rand%0d interrupt", n), {15'd0, interrupt}, {15'd0, m_int});
      if (prev_int && interrupt)
        check($sformatf("rand%0d back-to-back interrupt", n), 16'd1, 16'd0);
      prev_int = interrupt;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/j1_irq_ctrl.md
Name: j1_irq_ctrl

Overview:
- Interrupt controller sitting directly upstream of the j1 core: drives the core's one-cycle `interrupt` input, which makes the core execute "call 3FFE".
- Collects NSRC external request lines, latches them as pending, masks them and arbitrates.
- Exposes its state to the core's IO path through io_rd/io_wr/mem_addr/dout.
- Returns read data for the top-level io_din mux.

Parameters:
- NSRC, 8, number of interrupt sources (1..15).
- BASE, 16'h0100, IO base address; registers are at BASE+0/2/4/6, so BASE[2:0] must be 0.
- EDGE_MASK, 8'hFF (width NSRC), per-source type: bit=1 rising-edge latched, bit=0 level.

Ports:
- clk  in  1  system clock, same clock as the j1 core.
- reset  in  1  synchronous, active-high reset.
- io_rd  in  1  core IO read strobe.
- io_wr  in  1  core IO write strobe.
- io_addr  in  16  core mem_addr (st0).
- io_wdata  in  16  core dout (st1).
- io_rdata  out  16  read data; 0 when not selected.
- irq_src  in  NSRC  external request lines.
- hold  in  1  when 1, no interrupt may be issued this cycle; top level drives it during core memory-fetch cycles.
- interrupt  out  1  one-cycle request to the core.

Behaviour:
- Decode: sel = io_addr[15:3] == BASE[15:3]; register index = io_addr[2:1]; io_addr[0] ignored.
- Register map:
  - 0 PEND: read = pending bits; write = 1-to-clear.
  - 1 MASK: read/write enable bits.
  - 2 CTRL: bit0 = GIE, read/write; other bits read 0.
  - 3 CAUSE: read-only; bit15 = valid; bits[3:0] = lowest index i with pend[i]&mask[i]; all 0 if none.
- Unused upper bits read 0.
- io_rdata is combinational: valid in the same cycle as io_rd & sel; 0 otherwise. Reads have no side effects.
- Source path: s = irq_src, or its synchronized version when IRQ_SYNC_EN is defined. A prev register holds s from the previous cycle.
  - Edge source: pend[i] sets on s[i] & ~prev[i].
  - Level source: pend[i] = s[i] every cycle; W1C has no lasting effect on it.
- Simultaneous edge-set and W1C on the same bit: set wins.
- req = GIE & |(pend & mask) & ~hold.
- interrupt is a registered output: on an edge where req=1, interrupt<=1 and GIE<=0 in the same edge. Otherwise interrupt<=0. It is therefore never high for two consecutive cycles.
- If a CTRL write to GIE coincides with the issuing edge, the hardware clear wins (GIE=0).
- GIE=1 written while req conditions hold: interrupt is asserted the cycle after GIE reads 1.
- hold=1 only defers the request; pending state is kept, and the request issues on the first cycle with hold=0.
- Pending bits are never cleared by issuing. Software clears them via PEND W1C; the ISR re-enables GIE before returning.
- Write ordering: W1C/MASK/CTRL writes take effect at the clock edge of the io_wr cycle; req uses register values, not write data.
- Reset (synchronous, highest priority): pend=0, mask=0, GIE=0, prev=0, sync flops=0, interrupt=0. Reset mid-request drops any pending issue; interrupt is 0 the cycle after reset is sampled.
- Latency, from the clock edge that first samples a source high: pend set at the same edge without sync, 2 edges later with sync. interrupt goes high 1 edge after pend set, provided GIE=1, the bit is masked-in and hold=0.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer before edge detection; adds 2 cycles of latency; safe for asynchronous sources.
- Undefined: irq_src is used directly; sources must be synchronous to clk.

Test Plan:
- Reset: hold reset 3 cycles with irq_src=FF → interrupt=0; PEND, MASK, CTRL and CAUSE all read 0000.
- Edge IRQ: MASK=0004, CTRL=0001, pulse irq_src[2] for 1 cycle → PEND=0004. interrupt is high for exactly 1 cycle, 2 cycles after pulse sampling (4 with IRQ_SYNC_EN). CTRL then reads 0000 and CAUSE reads 8002.
- Priority/W1C: pend bits 1 and 5 set, MASK=0022 → CAUSE=8001. Write PEND=0002 → CAUSE=8005. Write PEND=0020 → CAUSE=0000.
- Hold deferral: request ready with hold=1 for 5 cycles → no interrupt. hold falls → interrupt asserts on the next edge, for one cycle.
- Level source (EDGE_MASK bit3=0): irq_src[3] held high, W1C PEND=0008 → PEND still reads 0008. Rewriting GIE=1 → a second single-cycle interrupt.
- Collision: edge on source 0 in the same cycle as a W1C of bit 0 → PEND bit0 = 1. A GIE write coinciding with issue → GIE reads 0 afterwards.
